// File: rtl/spi_target_sync_if.sv
// Local-side byte interface of spi_target_sync: transmit and receive
// valid/ready handshakes plus the frame-in-progress status.
// slave  : the SPI target end (drives tx_ready, rx_data, rx_valid, busy)
// master : the local logic feeding and draining the target
interface spi_target_sync_if #(
    parameter int DW = 8
);
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          busy;

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, busy
    );

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_target_sync.sv
// SPI mode 1 (CPOL=0, CPHA=1) target, LSB first, oversampled on clk.
// sclk/ss/mosi are synchronized, edges are turned into registered one-cycle
// pulses, and a full-duplex frame is shifted on those pulses. Bytes move to
// and from local logic through a one-deep transmit holder and a receive
// register with valid/ready handshakes.
// Optional feature macro SPI_TGT_OVR_EN: on overrun keep the pending byte,
// drop the new one and raise a sticky ovr flag; without it the new byte
// overwrites the pending one.
module spi_target_sync #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sclk,
    input  logic               ss,
    input  logic               mosi,
    output logic               miso,
    spi_target_sync_if.slave   bus
`ifdef SPI_TGT_OVR_EN
    ,
    output logic               ovr
`endif
);
    localparam int CW = $clog2(DW);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_s, ss_s, mosi_s;
    logic                   sclk_prev, ss_prev;
    logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic [CW-1:0]          cnt;
    logic                   last_bit;
    logic [DW-1:0]          tx_shift, rx_shift, rx_frame;
    logic [DW-1:0]          hold_data;
    logic                   hold_full;
    logic [DW-1:0]          rx_data_q;
    logic                   rx_valid_q;
    logic                   load, deliver, leave;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Synchronizers, then registered edge pulses (ss resets high so a
    // released reset never looks like a select edge while ss is idle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            ss_fall   <= 1'b0;
            ss_rise   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
            sclk_rise <= sclk_s & ~sclk_prev;
            sclk_fall <= ~sclk_s & sclk_prev;
            ss_fall   <= ~ss_s & ss_prev;
            ss_rise   <= ss_s & ~ss_prev;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state plus load/deliver/leave strobes; the DW-th falling edge
    // reloads and stays in SHIFT so back-to-back frames need no ss toggle.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        deliver  = 1'b0;
        leave    = 1'b0;
        last_bit = (cnt == CW'(DW - 1));
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nx = SHIFT;
                    load     = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_nx = IDLE;
                    leave    = 1'b1;
                end else if (sclk_fall && last_bit) begin
                    load    = 1'b1;
                    deliver = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Receive shifter with the bit landing this cycle merged in.
    always_comb begin
        rx_frame      = rx_shift;
        rx_frame[cnt] = mosi_s;
    end

    // Bit counter, miso and the two shifters. A mid-frame ss rise simply
    // parks everything; the partial rx bits are never delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            miso     <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
        end else begin
            if (state == IDLE || leave) begin
                cnt  <= '0;
                miso <= 1'b0;
            end else begin
                if (sclk_rise) miso <= tx_shift[cnt];
                if (sclk_fall) begin
                    rx_shift <= rx_frame;
                    cnt      <= last_bit ? '0 : cnt + 1'b1;
                end
            end
            if (load) tx_shift <= hold_full ? hold_data : '0;
        end
    end

    // Transmit holder: a load drains it, otherwise an accepted write fills
    // it; a write alongside a load of an empty holder waits for next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (load && hold_full) begin
            hold_full <= 1'b0;
        end else if (bus.tx_valid && !hold_full) begin
            hold_data <= bus.tx_data;
            hold_full <= 1'b1;
        end
    end

    // Receive register and overrun policy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
`ifdef SPI_TGT_OVR_EN
            ovr        <= 1'b0;
`endif
        end else begin
            if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;
            if (deliver) begin
`ifdef SPI_TGT_OVR_EN
                if (rx_valid_q && !bus.rx_ready) begin
                    ovr <= 1'b1;
                end else begin
                    rx_data_q  <= rx_frame;
                    rx_valid_q <= 1'b1;
                end
`else
                rx_data_q  <= rx_frame;
                rx_valid_q <= 1'b1;
`endif
            end
        end
    end

    assign bus.tx_ready = ~hold_full;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = (state == SHIFT) && (cnt != '0);
endmodule

// File: tb/tb_spi_target_sync.sv
// Bench for spi_target_sync: a behavioural SPI master plus queue-based model
// of the byte each frame should return and of the frames the consumer sees.
module tb_spi_target_sync;
    localparam int DW = 8;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic ss = 1'b1;
    logic mosi = 1'b0;
    logic miso;
`ifdef SPI_TGT_OVR_EN
    logic ovr;
`endif

    spi_target_sync_if #(.DW(DW)) ifc ();

    spi_target_sync #(.DW(DW), .SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sclk  (sclk),
        .ss    (ss),
        .mosi  (mosi),
        .miso  (miso),
        .bus   (ifc)
`ifdef SPI_TGT_OVR_EN
        ,
        .ovr   (ovr)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] tx_q[$];    // bytes waiting in the holder for coming frames
    logic [7:0] rx_exp[$];  // frames the consumer should accept, in order
    logic [7:0] rx_got[$];  // frames the consumer actually accepted

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer side: record every completed rx handshake.
    always @(negedge clk) begin
        #1;
        if (rst_n && ifc.rx_valid && ifc.rx_ready) rx_got.push_back(ifc.rx_data);
    end

    task automatic push_tx(input logic [7:0] b);
        int n;
        @(negedge clk);
        ifc.tx_data  = b;
        ifc.tx_valid = 1'b1;
        n = 0;
        while (!ifc.tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tx_accept_in_time", (n < 200), 1);
        @(negedge clk);
        ifc.tx_valid = 1'b0;
        tx_q.push_back(b);
    endtask

    task automatic ss_low(input int half);
        @(negedge clk);
        ss = 1'b0;
        repeat (half) @(negedge clk);
    endtask

    task automatic ss_high();
        @(negedge clk);
        ss = 1'b1;
        repeat (SS + 4) @(negedge clk);
    endtask

    // Mode 1 master: drive mosi on the rising edge, sample miso on the fall.
    task automatic spi_bits(input logic [7:0] mo, input int nb, input int half,
                            input bit lat, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            sclk = 1'b1;
            mosi = mo[i];
            repeat (half) @(negedge clk);
            mi[i] = miso;
            sclk  = 1'b0;
            if (lat && i == nb - 1) begin
                int n = 0;
                while (!ifc.rx_valid && n < 20) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("rx_valid_latency", n, SS + 2);
                repeat (half) @(negedge clk);
            end else begin
                repeat (half - 1) @(negedge clk);
            end
        end
    endtask

    task automatic frame(input logic [7:0] mo, input int half, input bit lat);
        logic [7:0] mi, exp;
        exp = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
        spi_bits(mo, 8, half, lat, mi);
        chk("miso_byte", mi, exp);
        rx_exp.push_back(mo);
    endtask

    task automatic rx_compare(input string tag);
        repeat (4) @(negedge clk);
        chk({tag, "_rx_count"}, rx_got.size(), rx_exp.size());
        while (rx_got.size() != 0 && rx_exp.size() != 0)
            chk({tag, "_rx_data"}, rx_got.pop_front(), rx_exp.pop_front());
        rx_got.delete();
        rx_exp.delete();
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_miso"}, miso, 0);
        chk({tag, "_tx_ready"}, ifc.tx_ready, 1);
        chk({tag, "_rx_valid"}, ifc.rx_valid, 0);
        chk({tag, "_rx_data"}, ifc.rx_data, 0);
        chk({tag, "_busy"}, ifc.busy, 0);
`ifdef SPI_TGT_OVR_EN
        chk({tag, "_ovr"}, ovr, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] dummy, b, ovr_exp;
        int half, nf;
        ifc.tx_data  = '0;
        ifc.tx_valid = 1'b0;
        ifc.rx_ready = 1'b1;

        // Reset, then release with ss idle.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (SS + 4) @(negedge clk);
        reset_outputs("reset");

        // Single frame with latency check.
        push_tx(8'hA5);
        ss_low(5);
        frame(8'h3C, 5, 1'b1);
        ss_high();
        rx_compare("single");

        // Back-to-back frames, second one underruns.
        push_tx(8'h11);
        ss_low(5);
        frame(8'hF0, 5, 1'b0);
        frame(8'h0F, 5, 1'b0);
        ss_high();
        rx_compare("b2b");

        // Abort after 4 bits, then a clean frame.
        ss_low(5);
        spi_bits(8'($urandom), 4, 5, 1'b0, dummy);
        repeat (SS + 3) @(negedge clk);
        chk("abort_busy_mid", ifc.busy, 1);
        ss_high();
        chk("abort_miso", miso, 0);
        chk("abort_busy", ifc.busy, 0);
        chk("abort_rx_valid", ifc.rx_valid, 0);
        rx_compare("abort");
        push_tx(8'($urandom));
        ss_low(6);
        frame(8'h5A, 6, 1'b0);
        ss_high();
        rx_compare("after_abort");

        // Randomized bursts.
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 1) push_tx(8'($urandom));
            half = $urandom_range(5, 8);
            nf   = $urandom_range(1, 3);
            ss_low(half);
            for (int f = 0; f < nf; f++) frame(8'($urandom), half, 1'b0);
            ss_high();
        end
        rx_compare("random");

        // Overrun with the consumer stalled.
        @(negedge clk);
        ifc.rx_ready = 1'b0;
        ss_low(5);
        spi_bits(8'h12, 8, 5, 1'b0, dummy);
        spi_bits(8'h34, 8, 5, 1'b0, dummy);
        ss_high();
`ifdef SPI_TGT_OVR_EN
        ovr_exp = 8'h12;
        chk("ovr_flag", ovr, 1);
`else
        ovr_exp = 8'h34;
`endif
        chk("ovr_rx_valid", ifc.rx_valid, 1);
        chk("ovr_rx_data", ifc.rx_data, ovr_exp);
        @(negedge clk);
        ifc.rx_ready = 1'b1;
        rx_exp.push_back(ovr_exp);
        rx_compare("overrun");

        // Reset in the middle of a frame.
        push_tx(8'($urandom));
        ss_low(5);
        spi_bits(8'($urandom), 5, 5, 1'b0, dummy);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_outputs("midrst");
        ss = 1'b1;
        tx_q.delete();
        rx_got.delete();
        rx_exp.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (SS + 4) @(negedge clk);
        b = 8'($urandom);
        push_tx(b);
        ss_low(5);
        frame(8'h81, 5, 1'b0);
        ss_high();
        rx_compare("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_target_sync.md
# spi_target_sync

Clock-synchronous SPI mode 1 (CPOL=0, CPHA=1) target: the peripheral end of the link driven by the team's SPI master, which sends 8-bit frames LSB first. It oversamples `sclk`, `ss` and `mosi` on the local system clock. It shifts a full-duplex frame, receiving on `mosi` while transmitting on `miso`. It exchanges bytes with local logic through valid/ready handshakes, so register files and FIFOs can sit behind it without touching the SPI clock domain.

## Interface
- `DW`, default 8: frame width in bits (≥2).
- `SYNC_STAGES`, default 2: synchronizer depth on `sclk`, `ss` and `mosi` (≥2).

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sclk`  in  1  SPI clock from the master; asynchronous to `clk`.
- `ss`  in  1  slave select, active-low; asynchronous.
- `mosi`  in  1  serial data from the master.
- `miso`  out  1  serial data to the master; driven to 0 while `ss` is high.
- `tx_data`  in  DW  next byte to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  the transmit holding register is empty.
- `rx_data`  out  DW  last received frame.
- `rx_valid`  out  1  `rx_data` is pending.
- `rx_ready`  in  1  the consumer accepts `rx_data`.
- `busy`  out  1  a frame is in progress (synced `ss` low and bit count ≠ 0).
- `ovr`  out  1  sticky overrun flag; present only with `SPI_TGT_OVR_EN`.

## Operation
- **Synchronization:** `sclk`, `ss` and `mosi` each pass through `SYNC_STAGES` flops. Edges are detected by comparing the synchronized value with its previous value.
- **States:**
  - IDLE (synced `ss` high): bit count is 0 and `miso` is 0.
  - On the synced `ss` falling edge, enter SHIFT and load the transmit shifter.
  - SHIFT (synced `ss` low):
    - Each synced `sclk` rising edge: `miso` ← tx shifter bit[cnt], LSB first.
    - Each synced `sclk` falling edge: rx shifter bit[cnt] ← synced `mosi`, then `cnt++`.
  - On the DW-th falling edge:
    - Deliver the received frame.
    - Reset `cnt` to 0.
    - Reload the tx shifter.
    - Stay in SHIFT, so back-to-back frames work without toggling `ss`.
- **Transmit holding register:**
  - `tx_valid && tx_ready` writes it and sets it full (`tx_ready`=0).
  - A shifter load consumes it and sets `tx_ready`=1.
  - If it is empty at a load, the shifter loads all zeros.
  - A write in the same cycle as a load of an empty holder does not reach that frame; the written byte stays held for the next frame.
- **Receive:** a delivered frame sets `rx_data` and `rx_valid`=1. `rx_valid && rx_ready` clears `rx_valid`.
- **Overrun:** a frame completes while `rx_valid`=1 and `rx_ready`=0. Behaviour depends on `SPI_TGT_OVR_EN` (see Configuration).
- **Abort:** synced `ss` rising mid-frame:
  - Bit count returns to 0 and `miso` goes to 0.
  - The partial frame is discarded; no `rx_valid`.
  - An already-loaded shifter byte is lost, and `tx_ready` is unaffected.
- **Reset:** `rst_n` low clears all state immediately.
  - `miso`=0, `rx_data`=0, `rx_valid`=0, `busy`=0, `ovr`=0.
  - `tx_ready`=1 and the holding register is empty.
  - State returns to IDLE.
  - Reset mid-frame drops the frame.

## Timing
- Required: `sclk` high and low phases each ≥ `SYNC_STAGES`+2 `clk` periods.
- Required: `ss` falling edge ≥ `SYNC_STAGES`+2 `clk` periods before the first `sclk` rising edge.
- `miso` is valid ≤ `SYNC_STAGES`+2 `clk` cycles after an `sclk` rising edge at the pin; the master samples it on the following falling edge.
- `mosi` is sampled with the same latency as the `sclk` falling edge.
- `rx_valid` asserts exactly `SYNC_STAGES`+2 `clk` cycles after the DW-th `sclk` falling edge at the pin.
- `tx_ready` rises in the cycle after the shifter load.
- Handshakes complete in the cycle where valid and ready are both high; zero bubble.

## Configuration
- Macro: `SPI_TGT_OVR_EN`.
- **Defined:**
  - On overrun, the new frame is dropped: `rx_data` is kept and `rx_valid` stays 1.
  - `ovr` is set and holds until reset.
- **Undefined:**
  - On overrun, `rx_data` is overwritten with the new frame and `rx_valid` stays 1.
  - No `ovr` port exists.

## Test plan
- **Reset values:** reset, then release with `ss`=1 → `miso`=0, `tx_ready`=1, `rx_valid`=0, `busy`=0.
- **Single frame:** preload `tx_data`=0xA5, master sends 0x3C (LSB first, `clk`/`sclk` = 10) → master reads 0xA5; `rx_data`=0x3C with `rx_valid`=1 `SYNC_STAGES`+2 cycles after the 8th falling edge.
- **Back-to-back with underrun:** hold `ss` low for 2 frames with only 0x11 preloaded, sending 0xF0 then 0x0F → master reads 0x11 then 0x00; two `rx_valid` events with 0xF0, 0x0F.
- **Abort:** `ss` rises after 4 bits → no `rx_valid`, `miso`=0; the next full frame of 0x5A is received correctly.
- **Overrun:** hold `rx_ready`=0 and send 0x12 then 0x34 → with the macro, `rx_data`=0x12 and `ovr`=1; without it, `rx_data`=0x34.
- **Mid-frame reset:** pulse `rst_n` low after 5 bits → outputs return to reset values immediately; the next frame is 0x81 with 0x81 received.
